// File: rtl/device_mailbox.sv
// device_mailbox: cluster device-bus responder providing a shared message
// FIFO, a hardware barrier across all cores, a requester-ID register and a
// free-running 32-bit cycle counter. Read data is registered, so it appears
// one cycle after the read strobe.
module device_mailbox #(
  parameter int NUM_CORES  = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    device_addr,
  input  logic          device_write_en,
  input  logic          device_read_en,
  input  logic [15:0]   device_data_out,
  input  logic [CW-1:0] device_core_id,
  output logic [15:0]   device_data_in,
  output logic          barrier_release
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [9:0] ADDR_FIFO_DATA = 10'h000;
  localparam logic [9:0] ADDR_FIFO_STAT = 10'h001;
  localparam logic [9:0] ADDR_BARRIER   = 10'h002;
  localparam logic [9:0] ADDR_CORE_ID   = 10'h003;
  localparam logic [9:0] ADDR_CYC_LO    = 10'h004;
  localparam logic [9:0] ADDR_CYC_HI    = 10'h005;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_GATHER = 1'b1;

  // FIFO state
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // Barrier state
  logic [0:0]           state_q, state_d;
  logic [NUM_CORES-1:0] arrived_q, arrived_d;
  logic [3:0]           generation_q, generation_d;
  logic                 release_q, release_d;

  // Counter and read path state
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] hi_shadow_q, hi_shadow_d;
  logic [15:0] data_in_q, data_in_d;

  // Access decode
  logic                 wr_access;
  logic                 rd_access;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_req;
  logic                 pop_req;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 stat_write;
  logic                 barrier_write;
  logic                 lo_read;
  logic [NUM_CORES-1:0] arrive_onehot;
  logic [NUM_CORES-1:0] arrived_merged;
  logic                 barrier_done;
  logic [15:0]          rd_value;

  // A simultaneous read and write is treated as a write only, so every
  // read side effect (pop, shadow capture) is gated by the absence of a write.
  always_comb begin
    wr_access      = device_write_en;
    rd_access      = device_read_en & ~device_write_en;
    fifo_full      = (count_q == CNTW'(FIFO_DEPTH));
    fifo_empty     = (count_q == '0);
    push_req       = wr_access && (device_addr == ADDR_FIFO_DATA);
    pop_req        = rd_access && (device_addr == ADDR_FIFO_DATA);
    push_ok        = push_req & ~fifo_full;
    pop_ok         = pop_req & ~fifo_empty;
    stat_write     = wr_access && (device_addr == ADDR_FIFO_STAT);
    barrier_write  = wr_access && (device_addr == ADDR_BARRIER);
    lo_read        = rd_access && (device_addr == ADDR_CYC_LO);
  end

  // One-hot of the requesting core; ids beyond NUM_CORES-1 map to no bit.
  always_comb begin
    arrive_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      arrive_onehot[i] = (device_core_id == CW'(i));
    end
    arrived_merged = arrived_q | arrive_onehot;
    barrier_done   = &arrived_merged;
  end

  // FIFO pointer, count and sticky error flag updates.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (stat_write) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (push_req) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CNTW'(1);
      end
    end
    if (pop_req) begin
      if (fifo_empty) begin
        unf_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q - CNTW'(1);
      end
    end
  end

  // Message storage is not reset; only entries between the pointers are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= device_data_out;
    end
  end

  // Barrier FSM: IDLE while nobody has arrived, GATHER once any core has.
  always_comb begin
    state_d      = state_q;
    arrived_d    = arrived_q;
    generation_d = generation_q;
    release_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (barrier_write && (|arrive_onehot)) begin
          if (barrier_done) begin
            arrived_d    = '0;
            generation_d = generation_q + 4'd1;
            release_d    = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            arrived_d = arrived_merged;
            state_d   = ST_GATHER;
          end
        end
      end
      ST_GATHER: begin
        if (barrier_write) begin
          if (barrier_done) begin
            arrived_d    = '0;
            generation_d = generation_q + 4'd1;
            release_d    = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            arrived_d = arrived_merged;
          end
        end
      end
      default: begin
        arrived_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Register read mux; values reflect state before this edge's updates.
  always_comb begin
    rd_value = 16'h0000;
    case (device_addr)
      ADDR_FIFO_DATA: rd_value = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_q];
      ADDR_FIFO_STAT: rd_value = {3'b000, 11'(count_q), ovf_q, unf_q};
      ADDR_BARRIER:   rd_value = {12'h000, generation_q};
      ADDR_CORE_ID:   rd_value = 16'(device_core_id);
      ADDR_CYC_LO:    rd_value = cycle_q[15:0];
      ADDR_CYC_HI:    rd_value = hi_shadow_q;
      default:        rd_value = 16'h0000;
    endcase
  end

  // Read data register holds between reads; a read/write collision returns zero.
  always_comb begin
    data_in_d = data_in_q;
    if (device_read_en && device_write_en) begin
      data_in_d = 16'h0000;
    end else if (device_read_en) begin
      data_in_d = rd_value;
    end
  end

  // Free-running cycle counter with a high-half shadow captured on low-half reads.
  always_comb begin
    cycle_d     = cycle_q + 32'd1;
    hi_shadow_d = lo_read ? cycle_q[31:16] : hi_shadow_q;
  end

  // All control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      state_q      <= ST_IDLE;
      arrived_q    <= '0;
      generation_q <= 4'd0;
      release_q    <= 1'b0;
      cycle_q      <= 32'd0;
      hi_shadow_q  <= 16'h0000;
      data_in_q    <= 16'h0000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      state_q      <= state_d;
      arrived_q    <= arrived_d;
      generation_q <= generation_d;
      release_q    <= release_d;
      cycle_q      <= cycle_d;
      hi_shadow_q  <= hi_shadow_d;
      data_in_q    <= data_in_d;
    end
  end

  assign device_data_in  = data_in_q;
  assign barrier_release = release_q;

endmodule

// File: tb/tb_device_mailbox.sv
// tb_device_mailbox: directed test of device_mailbox. A 16-core instance
// carries most traffic; a 4-core instance shares the bus for barrier rounds.
// Expected read data is queued at issue time and checked by a monitor.
module tb_device_mailbox;

  localparam logic [9:0] A_FIFO = 10'h000;
  localparam logic [9:0] A_STAT = 10'h001;
  localparam logic [9:0] A_BAR  = 10'h002;
  localparam logic [9:0] A_ID   = 10'h003;
  localparam logic [9:0] A_LO   = 10'h004;
  localparam logic [9:0] A_HI   = 10'h005;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  addr = '0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [15:0] data_out = '0;
  logic [3:0]  core_id = '0;
  logic [15:0] data_main, data_bar;
  logic        rel_main, rel_bar;

  typedef struct {
    bit          sel;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rel_main_cnt = 0;
  int   rel_bar_cnt = 0;

  device_mailbox #(.NUM_CORES(16), .FIFO_DEPTH(16)) u_main (
    .clk(clk), .reset(reset), .device_addr(addr),
    .device_write_en(write_en), .device_read_en(read_en),
    .device_data_out(data_out), .device_core_id(core_id),
    .device_data_in(data_main), .barrier_release(rel_main)
  );

  device_mailbox #(.NUM_CORES(4), .FIFO_DEPTH(16)) u_bar (
    .clk(clk), .reset(reset), .device_addr(addr),
    .device_write_en(write_en), .device_read_en(read_en),
    .device_data_out(data_out), .device_core_id(core_id[1:0]),
    .device_data_in(data_bar), .barrier_release(rel_bar)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one bus cycle starting just after a falling edge.
  task automatic apply_stimulus(input logic we, input logic re, input logic [9:0] a,
                                input logic [15:0] d, input logic [3:0] id);
    write_en = we;
    read_en  = re;
    addr     = a;
    data_out = d;
    core_id  = id;
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [3:0] id);
    apply_stimulus(1'b1, 1'b0, a, d, id);
  endtask

  task automatic do_read(input logic [9:0] a, input logic [3:0] id, input bit sel,
                         input logic [15:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.val  = exp;
    e.name = name;
    exp_q.push_back(e);
    apply_stimulus(1'b0, 1'b1, a, 16'h0000, id);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a read strobe seen at a rising edge is checked at the next falling edge.
  initial begin
    bit   sampled;
    exp_t e;
    forever begin
      @(posedge clk);
      sampled = reset && read_en;
      @(negedge clk);
      if (sampled) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_read: got 0x%0h, expected no response", data_main);
        end else begin
          e = exp_q.pop_front();
          check_output(e.name, 32'(e.sel ? data_bar : data_main), 32'(e.val));
        end
      end
    end
  end

  // Count release pulse cycles on both instances.
  always @(negedge clk) begin
    if (rel_main) rel_main_cnt++;
    if (rel_bar) rel_bar_cnt++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check_output("reset_data_main", 32'(data_main), 32'h0);
    check_output("reset_data_bar", 32'(data_bar), 32'h0);
    check_output("reset_rel_main", 32'(rel_main), 32'h0);
    check_output("reset_rel_bar", 32'(rel_bar), 32'h0);
    idle(2);
    reset = 1'b1;

    // Counter: read at the edge whose pre-edge count is 0x12345
    repeat (20'h12345) @(negedge clk);
    do_read(A_LO, 4'd0, 1'b0, 16'h2345, "cyc_lo");
    idle(7);
    do_read(A_HI, 4'd0, 1'b0, 16'h0001, "cyc_hi");
    do_read(A_ID, 4'd5, 1'b0, 16'h0005, "core_id_5");
    do_read(10'h006, 4'd0, 1'b0, 16'h0000, "unmapped_006");
    do_read(A_ID, 4'd5, 1'b0, 16'h0005, "core_id_5b");
    do_read(10'h3FF, 4'd0, 1'b0, 16'h0000, "unmapped_3ff");

    // FIFO basic push/pop
    do_write(A_FIFO, 16'h1111, 4'd0);
    do_write(A_FIFO, 16'h2222, 4'd0);
    do_write(A_FIFO, 16'h3333, 4'd0);
    do_read(A_FIFO, 4'd0, 1'b0, 16'h1111, "pop_1111");
    do_read(A_FIFO, 4'd0, 1'b0, 16'h2222, "pop_2222");
    do_read(A_FIFO, 4'd0, 1'b0, 16'h3333, "pop_3333");
    do_read(A_STAT, 4'd0, 1'b0, 16'h0000, "stat_after_basic");

    // Overflow and pointer wrap
    for (int i = 1; i <= 17; i++) do_write(A_FIFO, 16'(i), 4'd0);
    do_read(A_STAT, 4'd0, 1'b0, 16'h0042, "stat_full_ovf");
    do_write(A_STAT, 16'hFFFF, 4'd0);
    do_read(A_STAT, 4'd0, 1'b0, 16'h0040, "stat_full_clr");
    for (int i = 1; i <= 16; i++) do_read(A_FIFO, 4'd0, 1'b0, 16'(i), "pop_wrap");
    do_read(A_STAT, 4'd0, 1'b0, 16'h0000, "stat_drained");

    // Underflow
    do_read(A_ID, 4'd5, 1'b0, 16'h0005, "core_id_pre_unf");
    do_read(A_FIFO, 4'd0, 1'b0, 16'h0000, "pop_empty");
    do_read(A_STAT, 4'd0, 1'b0, 16'h0001, "stat_unf");
    do_write(A_STAT, 16'h0000, 4'd0);
    do_read(A_STAT, 4'd0, 1'b0, 16'h0000, "stat_unf_clr");

    // Read/write collision and hold-on-write
    do_read(A_ID, 4'd5, 1'b0, 16'h0005, "core_id_pre_rw");
    begin
      exp_t e;
      e.sel = 1'b0; e.val = 16'h0000; e.name = "rw_conflict";
      exp_q.push_back(e);
      apply_stimulus(1'b1, 1'b1, A_FIFO, 16'hABCD, 4'd5);
    end
    do_read(A_STAT, 4'd0, 1'b0, 16'h0004, "stat_after_rw");
    do_read(A_FIFO, 4'd0, 1'b0, 16'hABCD, "pop_abcd");
    do_write(A_FIFO, 16'h0077, 4'd0);
    check_output("hold_on_write", 32'(data_main), 32'hABCD);
    do_read(A_FIFO, 4'd0, 1'b0, 16'h0077, "pop_0077");

    // Barrier on the 4-core instance
    do_write(A_BAR, 16'h0000, 4'd0);
    do_write(A_BAR, 16'h0000, 4'd2);
    do_write(A_BAR, 16'h0000, 4'd2);
    do_write(A_BAR, 16'h0000, 4'd1);
    idle(2);
    check_output("no_release_partial", 32'(rel_bar_cnt), 32'd0);
    do_read(A_BAR, 4'd0, 1'b1, 16'h0000, "gen_partial");
    do_write(A_BAR, 16'h0000, 4'd3);
    idle(3);
    check_output("release_once", 32'(rel_bar_cnt), 32'd1);
    do_read(A_BAR, 4'd0, 1'b1, 16'h0001, "gen_1");
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 4; c++) do_write(A_BAR, 16'h0000, 4'(c));
    idle(2);
    check_output("release_17", 32'(rel_bar_cnt), 32'd17);
    do_read(A_BAR, 4'd0, 1'b1, 16'h0001, "gen_wrap");
    do_read(A_BAR, 4'd0, 1'b0, 16'h0000, "gen_main_16core");
    check_output("no_release_main", 32'(rel_main_cnt), 32'd0);

    // Asynchronous reset mid-gather with three words queued
    do_write(A_FIFO, 16'h0A01, 4'd0);
    do_write(A_FIFO, 16'h0A02, 4'd0);
    do_write(A_FIFO, 16'h0A03, 4'd0);
    do_write(A_BAR, 16'h0000, 4'd0);
    do_read(A_ID, 4'd5, 1'b0, 16'h0005, "core_id_pre_reset");
    #2 reset = 1'b0;
    #1;
    check_output("async_data_main", 32'(data_main), 32'h0);
    check_output("async_data_bar", 32'(data_bar), 32'h0);
    check_output("async_rel_main", 32'(rel_main), 32'h0);
    check_output("async_rel_bar", 32'(rel_bar), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rel_bar_cnt = 0;
    do_read(A_ID, 4'd5, 1'b0, 16'h0005, "core_id_post_reset");
    do_read(A_STAT, 4'd0, 1'b0, 16'h0000, "stat_post_reset");
    do_read(A_ID, 4'd5, 1'b1, 16'h0001, "core_id_bar_post_reset");
    do_read(A_BAR, 4'd0, 1'b1, 16'h0000, "gen_post_reset");
    do_write(A_BAR, 16'h0000, 4'd1);
    do_write(A_BAR, 16'h0000, 4'd2);
    do_write(A_BAR, 16'h0000, 4'd3);
    idle(2);
    check_output("arrivals_discarded", 32'(rel_bar_cnt), 32'd0);
    do_read(A_ID, 4'd5, 1'b1, 16'h0001, "core_id_bar_pre_gen");
    do_read(A_BAR, 4'd0, 1'b1, 16'h0000, "gen_after_partial");

    idle(3);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
